// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback assembler.
// Lane LANES-1 carries the scalar value of a result.
package wb_pkg;
    localparam int LANES = 16;
    localparam int XLEN  = 32;
    localparam int AW    = 4;
    localparam int CW    = $clog2(LANES);

    typedef logic [XLEN-1:0]             lane_t;
    typedef logic [LANES-1:0][XLEN-1:0]  vec_t;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        EMIT
    } wb_state_e;

    localparam logic [2:0]    CMD_V2S  = 3'b101;
    localparam logic [2:0]    CMD_NONE = 3'b000;
    localparam logic [AW-1:0] PC_ADDR  = 4'hF;
endpackage

// File: rtl/wb_lane_collector.sv
// Collects lane-serial vector-load beats into a full vector and requests
// a single-cycle emit once every lane has arrived.
//
// state   | meaning
// IDLE    | waiting for ld_start
// COLLECT | accepting beats, lane[cnt] <= ld_data
// EMIT    | buffer is complete, write port is claimed for one cycle
module wb_lane_collector
    import wb_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          ld_start,
    input  logic [AW-1:0] ld_rd,
    input  logic          ld_beat,
    input  lane_t         ld_data,
    output vec_t          vec,
    output logic [AW-1:0] rd,
    output logic          emit,
    output logic          busy,
    output logic          ld_ready,
    output logic          proto_err
);
    wb_state_e     state, state_nxt;
    logic [CW-1:0] cnt;

    always_comb begin
        state_nxt = state;
        proto_err = 1'b0;
        case (state)
            IDLE: begin
                if (ld_start) state_nxt = COLLECT;
                if (ld_beat)  proto_err = 1'b1;
            end
            COLLECT: begin
                if (ld_start) proto_err = 1'b1;
                if (ld_beat && cnt == CW'(LANES - 1)) state_nxt = EMIT;
            end
            EMIT:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            rd    <= '0;
            vec   <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && ld_start) begin
                rd  <= ld_rd;
                vec <= '0;
                cnt <= '0;
            end else if (state == COLLECT && ld_beat) begin
                vec[cnt] <= ld_data;
                cnt      <= cnt + CW'(1);
            end
        end
    end

    assign emit     = (state == EMIT);
    assign busy     = (state != IDLE);
    assign ld_ready = rst && (state != EMIT);
endmodule

// File: rtl/wb_assembler.sv
// Writeback assembler: arbitrates the collector emit against the direct path
// and registers the register-file write port. Optional counters: WB_PERF_EN.
module wb_assembler
    import wb_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [AW-1:0]         in_rd,
    input  logic                  in_vec,
    input  logic [2:0]            in_cmd,
    input  logic [LANES*XLEN-1:0] in_data,
    input  logic                  ld_start,
    input  logic [AW-1:0]         ld_rd,
    input  logic                  ld_beat,
    input  logic [XLEN-1:0]       ld_data,
    output logic                  ld_ready,
    output logic                  busy,
    output logic [AW-1:0]         busy_rd,
    output logic                  we3,
    output logic [AW-1:0]         ra3,
    output logic [LANES*XLEN-1:0] wd3,
    output logic                  selec_v_s_w,
    output logic [2:0]            cmd,
    output logic                  err,
    output logic [31:0]           perf_wr_s,
    output logic [31:0]           perf_wr_v,
    output logic [31:0]           perf_stall
);
    vec_t                  c_vec;
    logic [AW-1:0]         c_rd;
    logic                  c_emit, c_busy, c_proto_err;
    logic                  accept, pc_drop;
    logic                  we_nxt, sel_nxt;
    logic [AW-1:0]         ra_nxt;
    logic [LANES*XLEN-1:0] wd_nxt;
    logic [2:0]            cmd_nxt;

    wb_lane_collector u_collector (
        .clk       (clk),
        .rst       (rst),
        .ld_start  (ld_start),
        .ld_rd     (ld_rd),
        .ld_beat   (ld_beat),
        .ld_data   (ld_data),
        .vec       (c_vec),
        .rd        (c_rd),
        .emit      (c_emit),
        .busy      (c_busy),
        .ld_ready  (ld_ready),
        .proto_err (c_proto_err)
    );

    assign in_ready = rst && !c_emit;
    assign accept   = in_valid && in_ready;
    // R15 is the PC; scalar writes (incl. vector-to-scalar moves) to it are dropped
    assign pc_drop  = accept && (!in_vec || in_cmd == CMD_V2S) && in_rd == PC_ADDR;
    assign busy     = c_busy;
    assign busy_rd  = c_busy ? c_rd : '0;

    always_comb begin
        we_nxt  = 1'b0;
        ra_nxt  = ra3;
        wd_nxt  = wd3;
        sel_nxt = selec_v_s_w;
        cmd_nxt = cmd;
        if (c_emit) begin
            we_nxt  = 1'b1;
            ra_nxt  = c_rd;
            wd_nxt  = c_vec;
            sel_nxt = 1'b1;
            cmd_nxt = CMD_NONE;
        end else if (accept && !pc_drop) begin
            we_nxt  = 1'b1;
            ra_nxt  = in_rd;
            wd_nxt  = in_data;
            sel_nxt = in_vec;
            cmd_nxt = in_cmd;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we3         <= 1'b0;
            ra3         <= '0;
            wd3         <= '0;
            selec_v_s_w <= 1'b0;
            cmd         <= '0;
            err         <= 1'b0;
        end else begin
            we3         <= we_nxt;
            ra3         <= ra_nxt;
            wd3         <= wd_nxt;
            selec_v_s_w <= sel_nxt;
            cmd         <= cmd_nxt;
            if (pc_drop || c_proto_err) err <= 1'b1;
        end
    end

`ifdef WB_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_wr_s  <= '0;
            perf_wr_v  <= '0;
            perf_stall <= '0;
        end else begin
            if (we_nxt && sel_nxt)  perf_wr_v <= perf_wr_v + 32'd1;
            if (we_nxt && !sel_nxt) perf_wr_s <= perf_wr_s + 32'd1;
            if (in_valid && !in_ready) perf_stall <= perf_stall + 32'd1;
        end
    end
`else
    assign perf_wr_s  = '0;
    assign perf_wr_v  = '0;
    assign perf_stall = '0;
`endif
endmodule

// File: tb/tb_wb_assembler.sv
// Directed bench for wb_assembler with a transaction-level reference model
// checked every negedge, plus hand-computed literal checks.
module tb_wb_assembler;
    logic         clk;
    logic         rst;
    logic         in_valid, in_ready, in_vec;
    logic [3:0]   in_rd;
    logic [2:0]   in_cmd;
    logic [511:0] in_data;
    logic         ld_start, ld_beat, ld_ready, busy;
    logic [3:0]   ld_rd, busy_rd, ra3;
    logic [31:0]  ld_data;
    logic         we3, selec_v_s_w, err;
    logic [511:0] wd3;
    logic [2:0]   cmd;
    logic [31:0]  perf_wr_s, perf_wr_v, perf_stall;

    int n_vec = 0;
    int n_bad = 0;

    wb_assembler dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_vec(in_vec),
        .in_cmd(in_cmd), .in_data(in_data),
        .ld_start(ld_start), .ld_rd(ld_rd), .ld_beat(ld_beat), .ld_data(ld_data),
        .ld_ready(ld_ready), .busy(busy), .busy_rd(busy_rd),
        .we3(we3), .ra3(ra3), .wd3(wd3), .selec_v_s_w(selec_v_s_w), .cmd(cmd),
        .err(err), .perf_wr_s(perf_wr_s), .perf_wr_v(perf_wr_v), .perf_stall(perf_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    // Reference model: phase 0 = no load, 1 = gathering lanes, 2 = vector complete
    int          m_phase = 0;
    int          m_cnt   = 0;
    logic [3:0]  m_rd    = '0;
    logic        m_err   = 1'b0;
    logic [31:0] m_lane [16];
    logic        exp_we  = 1'b0;
    logic [3:0]  exp_ra  = '0;
    logic [511:0] exp_wd = '0;
    logic        exp_sel = 1'b0;
    logic [2:0]  exp_cmd = '0;
    logic [31:0] p_s = 0, p_v = 0, p_st = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_phase = 0; m_cnt = 0; m_rd = '0; m_err = 1'b0;
            exp_we = 1'b0; p_s = 0; p_v = 0; p_st = 0;
        end else begin
            exp_we = 1'b0;
            if (m_phase == 2) begin
                exp_we = 1'b1; exp_ra = m_rd; exp_sel = 1'b1; exp_cmd = 3'b000;
                for (int i = 0; i < 16; i++) exp_wd[i*32 +: 32] = m_lane[i];
                p_v++;
                if (in_valid) p_st++;
            end else if (in_valid) begin
                if ((!in_vec || in_cmd == 3'b101) && in_rd == 4'hF) m_err = 1'b1;
                else begin
                    exp_we = 1'b1; exp_ra = in_rd; exp_wd = in_data;
                    exp_sel = in_vec; exp_cmd = in_cmd;
                    if (in_vec) p_v++; else p_s++;
                end
            end
            if (m_phase == 0) begin
                if (ld_beat) m_err = 1'b1;
                if (ld_start) begin
                    m_phase = 1; m_cnt = 0; m_rd = ld_rd;
                    for (int i = 0; i < 16; i++) m_lane[i] = '0;
                end
            end else if (m_phase == 1) begin
                if (ld_start) m_err = 1'b1;
                if (ld_beat) begin
                    m_lane[m_cnt] = ld_data;
                    m_cnt++;
                    if (m_cnt == 16) m_phase = 2;
                end
            end else begin
                m_phase = 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("we3", we3, exp_we);
        if (exp_we) begin
            chk("ra3", ra3, exp_ra);
            chk("wd3", wd3, exp_wd);
            chk("selec_v_s_w", selec_v_s_w, exp_sel);
            chk("cmd", cmd, exp_cmd);
        end
        chk("err", err, m_err);
        chk("busy", busy, m_phase != 0);
        chk("busy_rd", busy_rd, (m_phase != 0) ? m_rd : 4'h0);
        chk("in_ready", in_ready, rst && m_phase != 2);
        chk("ld_ready", ld_ready, rst && m_phase != 2);
`ifdef WB_PERF_EN
        chk("perf_wr_s", perf_wr_s, p_s);
        chk("perf_wr_v", perf_wr_v, p_v);
        chk("perf_stall", perf_stall, p_st);
`else
        chk("perf_zero", {perf_wr_s, perf_wr_v, perf_stall}, 96'd0);
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        in_valid = 0; in_rd = '0; in_vec = 0; in_cmd = '0; in_data = '0;
        ld_start = 0; ld_rd = '0; ld_beat = 0; ld_data = '0;
    endtask

    task automatic do_reset();
        idle_in();
        rst = 0;
        tick(); tick();
        rst = 1;
    endtask

    task automatic load(input logic [3:0] rd, input logic [31:0] base, input int step);
        ld_start = 1; ld_rd = rd;
        tick();
        ld_start = 0;
        for (int i = 0; i < 16; i++) begin
            ld_beat = 1; ld_data = base + 32'(i * step);
            tick();
        end
        ld_beat = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_in();
        rst = 1;
        #2 rst = 0;
        tick(); tick();
        chk("rst_we3", we3, 0); chk("rst_wd3", wd3, 0); chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0); chk("rst_ld_ready", ld_ready, 0);
        rst = 1;
        tick();

        // direct scalar
        in_valid = 1; in_rd = 4'd5; in_vec = 0; in_cmd = 3'b010;
        in_data = '0; in_data[511:480] = 32'hDEADBEEF; in_data[31:0] = 32'h1234;
        tick();
        idle_in();
        chk("scalar_we3", we3, 1); chk("scalar_ra3", ra3, 4'd5);
        chk("scalar_sel", selec_v_s_w, 0); chk("scalar_lane15", wd3[511:480], 32'hDEADBEEF);
        tick();
        chk("scalar_we3_drop", we3, 0);

        // vector load rd=3, lanes 1..16
        load(4'd3, 32'd1, 1);
        chk("vld_busy_emit", busy, 1); chk("vld_we3_early", we3, 0);
        tick();
        chk("vld_we3", we3, 1); chk("vld_ra3", ra3, 4'd3); chk("vld_sel", selec_v_s_w, 1);
        chk("vld_busy_fall", busy, 0);
        for (int i = 0; i < 16; i++) chk("vld_lane", wd3[i*32 +: 32], 32'(i + 1));
        tick();
        chk("vld_we3_drop", we3, 0);

        // collision with emit
        do_reset();
        load(4'd7, 32'h700, 1);
        in_valid = 1; in_rd = 4'd2; in_vec = 0; in_cmd = 3'b001; in_data = {16{32'hAAAA5555}};
        chk("coll_in_ready", in_ready, 0);
        tick();
        chk("coll_vec_we3", we3, 1); chk("coll_vec_ra3", ra3, 4'd7);
        tick();
        idle_in();
        chk("coll_dir_we3", we3, 1); chk("coll_dir_ra3", ra3, 4'd2);
        chk("coll_dir_sel", selec_v_s_w, 0);
`ifdef WB_PERF_EN
        chk("coll_perf_stall", perf_stall, 32'd1);
`else
        chk("coll_perf_stall", perf_stall, 32'd0);
`endif
        tick();

        // reset mid-collect, then a clean load
        do_reset();
        ld_start = 1; ld_rd = 4'd9;
        tick();
        ld_start = 0;
        for (int i = 0; i < 7; i++) begin
            ld_beat = 1; ld_data = 32'hEE00 + 32'(i);
            tick();
        end
        ld_beat = 0;
        rst = 0;
        #1;
        chk("mid_rst_busy", busy, 0); chk("mid_rst_busy_rd", busy_rd, 0);
        chk("mid_rst_wd3", wd3, 0); chk("mid_rst_err", err, 0); chk("mid_rst_we3", we3, 0);
        tick(); tick();
        rst = 1;
        load(4'd10, 32'h10, 1);
        tick();
        chk("reload_we3", we3, 1); chk("reload_ra3", ra3, 4'd10);
        for (int i = 0; i < 16; i++) chk("reload_lane", wd3[i*32 +: 32], 32'h10 + 32'(i));
        tick();

        // PC protection
        do_reset();
        in_valid = 1; in_rd = 4'hF; in_vec = 0; in_cmd = 3'b011; in_data = {16{32'h0F0F0F0F}};
        tick();
        idle_in();
        chk("pc_scalar_we3", we3, 0); chk("pc_scalar_err", err, 1);
        do_reset();
        in_valid = 1; in_rd = 4'hF; in_vec = 1; in_cmd = 3'b000; in_data = {16{32'h13572468}};
        tick();
        chk("pc_vec_we3", we3, 1); chk("pc_vec_err", err, 0); chk("pc_vec_ra3", ra3, 4'hF);
        in_cmd = 3'b101;
        tick();
        idle_in();
        chk("pc_v2s_we3", we3, 0); chk("pc_v2s_err", err, 1);
        tick();

        // protocol errors
        do_reset();
        ld_beat = 1; ld_data = 32'h99;
        tick();
        idle_in();
        chk("beat_idle_err", err, 1); chk("beat_idle_busy", busy, 0);
        do_reset();
        ld_start = 1; ld_rd = 4'd4;
        tick();
        ld_rd = 4'd6;
        tick();
        idle_in();
        chk("start_coll_err", err, 1); chk("start_coll_busy_rd", busy_rd, 4'd4);
        do_reset();
        ld_start = 1; ld_beat = 1; ld_rd = 4'd8; ld_data = 32'h55;
        tick();
        idle_in();
        chk("start_beat_err", err, 1); chk("start_beat_busy", busy, 1);
        for (int i = 0; i < 16; i++) begin
            ld_beat = 1; ld_data = 32'h100 + 32'(i);
            tick();
        end
        ld_beat = 0;
        tick();
        chk("start_beat_we3", we3, 1); chk("start_beat_lane0", wd3[31:0], 32'h100);
        chk("start_beat_lane15", wd3[511:480], 32'h10F);
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
